// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output path.
//   CW_DEFAULT  : default colour component width
//   MODE_*      : encodings of the output colour mode (mode_in / mode_act_out)
package vga_pkg;

  localparam int CW_DEFAULT = 10;

  localparam logic [1:0] MODE_COLOUR = 2'b00;
  localparam logic [1:0] MODE_GREY   = 2'b01;
  localparam logic [1:0] MODE_GREEN  = 2'b10;
  localparam logic [1:0] MODE_AMBER  = 2'b11;

endpackage

// File: rtl/vga_to_greyscale.sv
// Combinational luma core.
//   r, g, b : colour components, CW bits each
//   y       : unsaturated luma, CW+1 bits
// Shift-and-add approximation of 0.28R + 0.56G + 0.125B. The result is kept
// one bit wider than the inputs; clamping is left to the caller.
module vga_to_greyscale
  import vga_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  output logic [CW:0]   y
);

  localparam int YW = CW + 1;

  always_comb begin
    y = YW'(r >> 2) + YW'(r >> 5)
      + YW'(g >> 1) + YW'(g >> 4)
      + YW'(b >> 4) + YW'(b >> 4);
  end

endmodule

// File: rtl/vga_colour_mode_pipe.sv
// Registered video output stage: colour / greyscale / green / amber.
//   clk_in, rst_n_in, ce_in     : pixel clock, sync active-low reset, pixel enable
//   r_in, g_in, b_in            : incoming colour components (CW bits)
//   hs_in, vs_in, blank_in      : incoming syncs and blanking
//   mode_in                     : requested mode, sampled only at a vsync start
//   r_out, g_out, b_out         : processed colour, 2 ce after input
//   hs_out, vs_out, blank_out   : syncs/blank delayed 2 ce to match the colour
//   mode_act_out                : mode currently latched
// Stage 1 registers the raw pixel together with the mode that applies to it;
// stage 2 derives luma, applies the tint and blanking, and registers outputs.
module vga_colour_mode_pipe
  import vga_pkg::*;
#(
  parameter int   CW       = CW_DEFAULT,
  parameter logic SYNC_ACT = 1'b0
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          ce_in,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_in,
  input  logic [1:0]    mode_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          blank_out,
  output logic [1:0]    mode_act_out
);

  localparam logic [CW-1:0] C_MAX = '1;

  // Stage 1 state
  logic [CW-1:0] s1_r_reg, s1_g_reg, s1_b_reg;
  logic          s1_hs_reg, s1_vs_reg, s1_blank_reg;
  logic [1:0]    s1_mode_reg;

  // Mode latch and vsync edge detector
  logic [1:0]    mode_act_reg;
  logic          vs_prev_reg;
  logic          vs_start;
  logic [1:0]    mode_next;

  // Stage 2 / output state
  logic [2:0][CW-1:0] rgb_reg;
  logic               hs_reg, vs_reg, blank_reg;

  assign vs_start  = ce_in & (vs_in == SYNC_ACT) & (vs_prev_reg != SYNC_ACT);
  // The new mode already applies to the pixel captured on the vsync edge.
  assign mode_next = vs_start ? mode_in : mode_act_reg;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_r_reg     <= '0;
      s1_g_reg     <= '0;
      s1_b_reg     <= '0;
      s1_hs_reg    <= ~SYNC_ACT;
      s1_vs_reg    <= ~SYNC_ACT;
      s1_blank_reg <= 1'b1;
      s1_mode_reg  <= MODE_COLOUR;
      mode_act_reg <= MODE_COLOUR;
      vs_prev_reg  <= ~SYNC_ACT;
    end else if (ce_in) begin
      s1_r_reg     <= r_in;
      s1_g_reg     <= g_in;
      s1_b_reg     <= b_in;
      s1_hs_reg    <= hs_in;
      s1_vs_reg    <= vs_in;
      s1_blank_reg <= blank_in;
      s1_mode_reg  <= mode_next;
      mode_act_reg <= mode_next;
      vs_prev_reg  <= vs_in;
    end
  end

  // Stage 2: luma, clamp, tint
  logic [CW:0]        y_raw;
  logic [CW-1:0]      y_sat;
  logic [2:0][CW-1:0] tint_next;
  logic [2:0][CW-1:0] rgb_next;

  vga_to_greyscale #(.CW(CW)) u_grey (
    .r (s1_r_reg),
    .g (s1_g_reg),
    .b (s1_b_reg),
    .y (y_raw)
  );

  assign y_sat = (y_raw > {1'b0, C_MAX}) ? C_MAX : y_raw[CW-1:0];

  always_comb begin
    tint_next[0] = s1_r_reg;
    tint_next[1] = s1_g_reg;
    tint_next[2] = s1_b_reg;
    case (s1_mode_reg)
      MODE_GREY: begin
        tint_next[0] = y_sat;
        tint_next[1] = y_sat;
        tint_next[2] = y_sat;
      end
      MODE_GREEN: begin
        tint_next[0] = '0;
        tint_next[1] = y_sat;
        tint_next[2] = '0;
      end
      MODE_AMBER: begin
        tint_next[0] = y_sat;
        tint_next[1] = (y_sat >> 1) + (y_sat >> 2);
        tint_next[2] = '0;
      end
      default: ;
    endcase
  end

  // Blanking overrides every mode.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_next[gi] = s1_blank_reg ? '0 : tint_next[gi];
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rgb_reg   <= '0;
      hs_reg    <= ~SYNC_ACT;
      vs_reg    <= ~SYNC_ACT;
      blank_reg <= 1'b1;
    end else if (ce_in) begin
      rgb_reg   <= rgb_next;
      hs_reg    <= s1_hs_reg;
      vs_reg    <= s1_vs_reg;
      blank_reg <= s1_blank_reg;
    end
  end

  assign r_out        = rgb_reg[0];
  assign g_out        = rgb_reg[1];
  assign b_out        = rgb_reg[2];
  assign hs_out       = hs_reg;
  assign vs_out       = vs_reg;
  assign blank_out    = blank_reg;
  assign mode_act_out = mode_act_reg;

endmodule

// File: tb/tb_vga_colour_mode_pipe.sv
// Self-checking bench for vga_colour_mode_pipe (CW=10, negative syncs).
// Expected pixels are computed when driven, queued, and compared when they
// emerge two ce cycles later.
module tb_vga_colour_mode_pipe;

  localparam int CW = 10;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          hs;
    logic          vs;
    logic          blank;
  } pix_t;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          ce_in = 1'b0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_in = 1'b1, vs_in = 1'b1, blank_in = 1'b1;
  logic [1:0]    mode_in = 2'b00;
  logic [CW-1:0] r_out, g_out, b_out;
  logic          hs_out, vs_out, blank_out;
  logic [1:0]    mode_act_out;

  vga_colour_mode_pipe #(.CW(CW), .SYNC_ACT(1'b0)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .ce_in        (ce_in),
    .r_in         (r_in),
    .g_in         (g_in),
    .b_in         (b_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_in     (blank_in),
    .mode_in      (mode_in),
    .r_out        (r_out),
    .g_out        (g_out),
    .b_out        (b_out),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .blank_out    (blank_out),
    .mode_act_out (mode_act_out)
  );

  always #5 clk_in = ~clk_in;

  int   n_vec  = 0;
  int   n_miss = 0;
  pix_t exp_q[$];
  pix_t last_exp;
  pix_t rst_pix;
  logic [1:0] mode_m;
  logic       vs_prev_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic pix_t model(input logic [CW-1:0] r, input logic [CW-1:0] g,
                                 input logic [CW-1:0] b, input logic hs, input logic vs,
                                 input logic blank, input logic [1:0] mode);
    pix_t p;
    int y;
    y = (int'(r) >> 2) + (int'(r) >> 5) + (int'(g) >> 1) + (int'(g) >> 4) + 2 * (int'(b) >> 4);
    if (y > 1023) y = 1023;
    case (mode)
      2'b01:   begin p.r = CW'(y); p.g = CW'(y); p.b = CW'(y); end
      2'b10:   begin p.r = '0;     p.g = CW'(y); p.b = '0;     end
      2'b11:   begin p.r = CW'(y); p.g = CW'((y >> 1) + (y >> 2)); p.b = '0; end
      default: begin p.r = r;      p.g = g;      p.b = b;      end
    endcase
    if (blank) begin p.r = '0; p.g = '0; p.b = '0; end
    p.hs = hs; p.vs = vs; p.blank = blank;
    return p;
  endfunction

  task automatic cmp_out(input string what, input pix_t e);
    chk({what, ".r"}, 32'(r_out), 32'(e.r));
    chk({what, ".g"}, 32'(g_out), 32'(e.g));
    chk({what, ".b"}, 32'(b_out), 32'(e.b));
    chk({what, ".hs"}, 32'(hs_out), 32'(e.hs));
    chk({what, ".vs"}, 32'(vs_out), 32'(e.vs));
    chk({what, ".blank"}, 32'(blank_out), 32'(e.blank));
  endtask

  // Drive one clock with the given inputs, update the model, check outputs.
  task automatic cyc(input logic ce, input logic [CW-1:0] r, input logic [CW-1:0] g,
                     input logic [CW-1:0] b, input logic hs, input logic vs,
                     input logic blank, input logic [1:0] mode);
    pix_t e;
    @(negedge clk_in);
    ce_in = ce; r_in = r; g_in = g; b_in = b;
    hs_in = hs; vs_in = vs; blank_in = blank; mode_in = mode;
    if (ce) begin
      if (vs == 1'b0 && vs_prev_m != 1'b0) mode_m = mode;
      vs_prev_m = vs;
      exp_q.push_back(model(r, g, b, hs, vs, blank, mode_m));
    end
    @(posedge clk_in);
    #1;
    if (ce) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        cmp_out("pix", e);
        last_exp = e;
      end
    end else begin
      cmp_out("hold", last_exp);
    end
    chk("mode_act", 32'(mode_act_out), 32'(mode_m));
    $display("cyc ce=%0b in=%h,%h,%h hs=%0b vs=%0b bl=%0b mode_in=%0d -> out=%h,%h,%h hs=%0b vs=%0b bl=%0b act=%0d",
             ce, r, g, b, hs, vs, blank, mode, r_out, g_out, b_out, hs_out, vs_out, blank_out, mode_act_out);
  endtask

  // One reset clock with live pixel data on the inputs; outputs must clear.
  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0; ce_in = 1'b1;
    r_in = 10'h3FF; g_in = 10'h155; b_in = 10'h0AA;
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    @(posedge clk_in);
    #1;
    cmp_out("rst", rst_pix);
    chk("rst.mode_act", 32'(mode_act_out), 32'd0);
    $display("reset -> out=%h,%h,%h hs=%0b vs=%0b bl=%0b act=%0d",
             r_out, g_out, b_out, hs_out, vs_out, blank_out, mode_act_out);
    rst_n_in = 1'b1;
    exp_q.delete();
    exp_q.push_back(rst_pix);   // stage 1 holds reset values after release
    last_exp  = rst_pix;
    mode_m    = 2'b00;
    vs_prev_m = 1'b1;
  endtask

  task automatic vs_pulse(input logic [1:0] mode);
    cyc(1'b1, '0, '0, '0, 1'b1, 1'b0, 1'b1, mode);
    cyc(1'b1, '0, '0, '0, 1'b1, 1'b1, 1'b1, mode);
  endtask

  initial begin
    rst_pix = '{r: '0, g: '0, b: '0, hs: 1'b1, vs: 1'b1, blank: 1'b1};
    mode_m = 2'b00;
    vs_prev_m = 1'b1;
    last_exp = rst_pix;

    // 1: reset then colour passthrough
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 10'h3FF, 10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 2'b00);

    // 2: greyscale
    vs_pulse(2'b01);
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 2; i++) cyc(1'b1, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1, 1'b0, 2'b01);

    // 3: green then amber
    vs_pulse(2'b10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b1, 1'b0, 2'b10);
    vs_pulse(2'b11);
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b11);

    // 4: back to colour; mid-frame requests ignored until the vs edge,
    //    pixel on the edge cycle already amber, long vs updates once
    vs_pulse(2'b00);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b01);
    cyc(1'b1, 10'h120, 10'h240, 10'h360, 1'b1, 1'b1, 1'b0, 2'b11);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b11);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 10'h200, 10'h100, 10'h080, 1'b1, 1'b0, 1'b0, 2'b10);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 2'b00);

    // 5: ce 1-0-0-1, including a vs edge spanning the stalled cycles
    cyc(1'b1, 10'h111, 10'h222, 10'h333, 1'b0, 1'b1, 1'b0, 2'b00);
    cyc(1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 10'h000, 10'h3FF, 10'h000, 1'b1, 1'b0, 1'b0, 2'b01);
    cyc(1'b1, 10'h2AA, 10'h155, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b01);
    cyc(1'b0, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 2'b10);
    cyc(1'b1, 10'h3FF, 10'h000, 10'h000, 1'b1, 1'b0, 1'b0, 2'b10);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b10);
    cyc(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 2'b10);

    // 6: reset mid-line, then valid data 2 ce after release
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h3FF, 10'h000, 10'h155, 1'b1, 1'b1, 1'b0, 2'b11);

    // Random traffic: random ce, modes, syncs and blanking
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 10'($urandom), 10'($urandom), 10'($urandom),
          1'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
          2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
